// File: rtl/hc161_ctrl_pkg.sv
// Shared types and defaults for the 74HC161 counter controller.
// Holds the controller state encoding and the default counter/tally widths.
package hc161_ctrl_pkg;

    localparam int unsigned DefaultWidth = 4;
    localparam int unsigned DefaultWrapW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StHold,
        StStep,
        StDone
    } state_e;

endpackage

// File: rtl/hc161_wrap_cnt.sv
// Saturating period tally with synchronous clear.
// Stops at all-ones so a long free run never appears to restart from zero.
module hc161_wrap_cnt
    import hc161_ctrl_pkg::*;
#(
    parameter int unsigned Width = DefaultWrapW
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hc161_ctrl.sv
// Sequencer for an external 74HC161-style counter: load, run to a limit,
// reload or stop, with pause and single-step, and a tally of completed periods.
module hc161_ctrl
    import hc161_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned WRAP_W = DefaultWrapW
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic              STOP,
    input  logic              STEP,
    input  logic              ONESHOT,
    input  logic [WIDTH-1:0]  INIT,
    input  logic [WIDTH-1:0]  LIMIT,
    input  logic [WIDTH-1:0]  Q_IN,
    output logic              ENP,
    output logic              ENT,
    output logic              LD,
    output logic [WIDTH-1:0]  PRE,
    output logic              TC,
    output logic              BUSY,
    output logic [WRAP_W-1:0] WRAPS
);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] init_d, init_q;
    logic [WIDTH-1:0] limit_d, limit_q;
    logic             at_limit;
    state_e           resume_st;

    assign at_limit  = (Q_IN == limit_q);
    // A step cycle behaves like run but always falls back to hold.
    assign resume_st = (state_q == StStep) ? StHold : StRun;

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        limit_d = limit_q;
        ENP     = 1'b0;
        ENT     = 1'b0;
        LD      = 1'b0;
        TC      = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (START && !STOP) begin
                    init_d  = INIT;
                    limit_d = LIMIT;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                LD      = 1'b1;
                state_d = STOP ? StHold : StRun;
            end
            StRun, StStep: begin
                if (STOP) begin
                    // Pause takes effect this cycle so the counter freezes in place.
                    ENT     = 1'b1;
                    state_d = StHold;
                end else if (at_limit) begin
                    TC = 1'b1;
                    if (ONESHOT) begin
                        state_d = StDone;
                    end else begin
                        LD      = 1'b1;
                        state_d = resume_st;
                    end
                end else begin
                    ENP     = 1'b1;
                    ENT     = 1'b1;
                    state_d = resume_st;
                end
            end
            StHold: begin
                ENT = 1'b1;
                if (!STOP) begin
                    if (START) begin
                        state_d = StRun;
                    end else if (STEP) begin
                        state_d = StStep;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= StIdle;
            init_q  <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            limit_q <= limit_d;
        end
    end

    hc161_wrap_cnt #(
        .Width(WRAP_W)
    ) u_wrap_cnt (
        .clk_i  (CLK),
        .clr_i  (CLR),
        .inc_i  (TC),
        .count_o(WRAPS)
    );

    assign PRE  = init_q;
    assign BUSY = state_q inside {StLoad, StRun, StHold, StStep};

endmodule

// File: tb/tb_hc161_ctrl.sv
// Closed-loop bench: behavioural 4-bit counter fed by hc161_ctrl, per-cycle
// expectations queued by the stimulus and checked by an independent monitor.
module tb_hc161_ctrl;

    logic       CLK = 1'b0;
    logic       clr = 1'b1, start = 1'b0, stop = 1'b0, step = 1'b0, oneshot = 1'b0;
    logic [3:0] init = 4'd0, limit = 4'd0;
    logic [3:0] q = 4'd0;
    logic       enp, ent, ld, tc, busy;
    logic [3:0] pre;
    logic [7:0] wraps;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];

    // {ENP, ENT, LD, TC, BUSY}
    localparam logic [4:0] Off  = 5'b00000;
    localparam logic [4:0] LdB  = 5'b00101;
    localparam logic [4:0] Cnt  = 5'b11001;
    localparam logic [4:0] Hld  = 5'b01001;
    localparam logic [4:0] TcRl = 5'b00111;
    localparam logic [4:0] TcOs = 5'b00011;

    always #5 CLK = ~CLK;

    hc161_ctrl #(
        .WIDTH (4),
        .WRAP_W(8)
    ) dut (
        .CLK    (CLK),
        .CLR    (clr),
        .START  (start),
        .STOP   (stop),
        .STEP   (step),
        .ONESHOT(oneshot),
        .INIT   (init),
        .LIMIT  (limit),
        .Q_IN   (q),
        .ENP    (enp),
        .ENT    (ent),
        .LD     (ld),
        .PRE    (pre),
        .TC     (tc),
        .BUSY   (busy),
        .WRAPS  (wraps)
    );

    always @(posedge CLK) begin
        if (ld === 1'b1) begin
            q <= pre;
        end else if ((enp & ent) === 1'b1) begin
            q <= q + 4'd1;
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [20:0] act;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                e   = sb.pop_front();
                act = {q, enp, ent, ld, tc, busy, pre, wraps};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %0s: got q=%h enp/ent/ld/tc/busy=%b pre=%h wraps=%0d, want q=%h enp/ent/ld/tc/busy=%b pre=%h wraps=%0d",
                             e.name, act[20:17], act[16:12], act[11:8], act[7:0],
                             e.v[20:17], e.v[16:12], e.v[11:8], e.v[7:0]);
                end
            end
        end
    end

    task automatic cyc(input string nm, input logic c, input logic s, input logic p,
                       input logic t, input logic [3:0] eq, input logic [4:0] ectl,
                       input logic [3:0] epre, input logic [7:0] ew);
        exp_t e;
        clr   = c;
        start = s;
        stop  = p;
        step  = t;
        e.name = nm;
        e.v    = {eq, ectl, epre, ew};
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        @(posedge CLK);
        #1;
        cyc("reset_state", 1, 0, 0, 0, 4'd0, Off, 4'd0, 8'd0);

        // Repeating 3..7
        oneshot = 1'b0; init = 4'd3; limit = 4'd7;
        cyc("rep_idle",   0, 1, 0, 0, 4'd0, Off,  4'd0, 8'd0);
        cyc("rep_load",   0, 0, 0, 0, 4'd0, LdB,  4'd3, 8'd0);
        cyc("rep_q3",     0, 0, 0, 0, 4'd3, Cnt,  4'd3, 8'd0);
        cyc("rep_q4",     0, 0, 0, 0, 4'd4, Cnt,  4'd3, 8'd0);
        cyc("rep_q5",     0, 0, 0, 0, 4'd5, Cnt,  4'd3, 8'd0);
        cyc("rep_q6",     0, 0, 0, 0, 4'd6, Cnt,  4'd3, 8'd0);
        cyc("rep_tc1",    0, 0, 0, 0, 4'd7, TcRl, 4'd3, 8'd0);
        cyc("rep_q3b",    0, 0, 0, 0, 4'd3, Cnt,  4'd3, 8'd1);
        cyc("rep_q4b",    0, 0, 0, 0, 4'd4, Cnt,  4'd3, 8'd1);
        cyc("rep_q5b",    0, 0, 0, 0, 4'd5, Cnt,  4'd3, 8'd1);
        cyc("rep_q6b",    0, 0, 0, 0, 4'd6, Cnt,  4'd3, 8'd1);
        cyc("rep_tc2",    0, 0, 0, 0, 4'd7, TcRl, 4'd3, 8'd1);
        cyc("rep_wraps2", 0, 0, 0, 0, 4'd3, Cnt,  4'd3, 8'd2);
        cyc("rep_q4c",    0, 0, 0, 0, 4'd4, Cnt,  4'd3, 8'd2);

        // Pause, single step, resume
        cyc("stop_q5",    0, 0, 1, 0, 4'd5, Hld,  4'd3, 8'd2);
        cyc("hold_q5",    0, 0, 0, 0, 4'd5, Hld,  4'd3, 8'd2);
        cyc("hold_step",  0, 0, 0, 1, 4'd5, Hld,  4'd3, 8'd2);
        cyc("step_cycle", 0, 0, 0, 0, 4'd5, Cnt,  4'd3, 8'd2);
        cyc("hold_q6",    0, 1, 0, 0, 4'd6, Hld,  4'd3, 8'd2);
        cyc("resume_q6",  0, 0, 0, 0, 4'd6, Cnt,  4'd3, 8'd2);
        cyc("resume_tc",  0, 0, 0, 0, 4'd7, TcRl, 4'd3, 8'd2);

        // Clear mid-run with three periods tallied
        cyc("clr_mid_run", 1, 0, 0, 0, 4'd3, Cnt, 4'd3, 8'd3);
        cyc("after_clr",   0, 0, 0, 0, 4'd4, Off, 4'd0, 8'd0);
        cyc("no_restart",  0, 0, 0, 0, 4'd4, Off, 4'd0, 8'd0);

        // START and STOP together in idle
        cyc("both_high",   0, 1, 1, 0, 4'd4, Off, 4'd0, 8'd0);
        cyc("both_idle1",  0, 0, 0, 0, 4'd4, Off, 4'd0, 8'd0);
        cyc("both_idle2",  0, 0, 0, 0, 4'd4, Off, 4'd0, 8'd0);

        // Oneshot 14..1 wrapping through zero
        oneshot = 1'b1; init = 4'd14; limit = 4'd1;
        cyc("os_idle",  0, 1, 0, 0, 4'd4,  Off,  4'd0,  8'd0);
        cyc("os_load",  0, 0, 0, 0, 4'd4,  LdB,  4'd14, 8'd0);
        cyc("os_q14",   0, 0, 0, 0, 4'd14, Cnt,  4'd14, 8'd0);
        cyc("os_q15",   0, 0, 0, 0, 4'd15, Cnt,  4'd14, 8'd0);
        cyc("os_q0",    0, 0, 0, 0, 4'd0,  Cnt,  4'd14, 8'd0);
        cyc("os_tc",    0, 0, 0, 0, 4'd1,  TcOs, 4'd14, 8'd0);
        cyc("os_done1", 0, 0, 0, 0, 4'd1,  Off,  4'd14, 8'd1);
        cyc("os_done2", 0, 0, 0, 0, 4'd1,  Off,  4'd14, 8'd1);

        // INIT == LIMIT: terminal every run cycle, tally saturates
        oneshot = 1'b0; init = 4'd9; limit = 4'd9;
        cyc("eq_start", 0, 1, 0, 0, 4'd1, Off, 4'd14, 8'd1);
        cyc("eq_load",  0, 0, 0, 0, 4'd1, LdB, 4'd9,  8'd1);
        for (int k = 0; k < 260; k++) begin
            cyc("eq_sat", 0, 0, 0, 0, 4'd9, TcRl, 4'd9, (k < 254) ? 8'(k + 1) : 8'd255);
        end
        cyc("eq_clr",   1, 0, 0, 0, 4'd9, TcRl, 4'd9, 8'd255);
        cyc("eq_idle",  0, 0, 0, 0, 4'd9, Off,  4'd0, 8'd0);

        repeat (2) @(posedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
